l2_mem_bridge: RTL and testbench

Sits directly downstream of the coherence bus controller, on the L2 side of the bus controller interface. Accepts the controller's 64-bit L2 requests (l2REN/l2WEN, l2addr, l2store) and reports progress through l2state and l2load. Each request becomes two sequential 32-bit beats on a single-ported word memory bus, low word first. Adds alignment checking, memory error forwarding and a per-beat timeout, so the bus controller never hangs on a stalled memory.

---
 rtl/l2_mem_bridge.sv | 180 ++++++++++++++++++
 tb/tb_l2_mem_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_bridge.sv
// Bridges 64-bit L2 requests from the coherence bus controller onto a 32-bit word
// memory bus as two beats, low word first, with alignment, error and timeout handling.
module l2_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        l2REN,
    input  logic        l2WEN,
    input  logic [31:0] l2addr,
    input  logic [63:0] l2store,
    output logic [63:0] l2load,
    output logic [1:0]  l2state,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_error
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    function automatic l2_state_t l2state_of(input state_t st);
        case (st)
            IDLE:                    l2state_of = L2_FREE;
            RD0, RD1, WR0, WR1:      l2state_of = L2_BUSY;
            DONE:                    l2state_of = L2_ACCESS;
            ERR:                     l2state_of = L2_ERROR;
            default:                 l2state_of = L2_ERROR;
        endcase
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [31:0]   addr_r, base_s, mem_addr_s;
    logic [63:0]   store_r, store_s;
    logic [31:0]   mem_wdata_s;
    logic [63:0]   l2load_r;
    l2_state_t     l2state_r;
    logic          mem_ren_r, mem_wen_r;
    logic [31:0]   mem_addr_r, mem_wdata_r;
    logic          lat_s, lo_en_s, hi_en_s;

    // Next-state, timeout counter and capture-enable logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        lat_s   = 1'b0;
        lo_en_s = 1'b0;
        hi_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {CW{1'b0}};
                if (l2REN ^ l2WEN) begin
                    lat_s = 1'b1;
                    if (l2addr[2:0] != 3'b000) begin
                        state_s = ERR;
                    end else if (l2REN) begin
                        state_s = RD0;
                    end else begin
                        state_s = WR0;
                    end
                end else if (l2REN & l2WEN) begin
                    state_s = ERR;
                end else begin
                    state_s = IDLE;
                end
            end
            RD0, RD1, WR0, WR1: begin
                if (mem_busy) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = ERR;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_s = {CW{1'b0}};
                    if (mem_error) begin
                        state_s = ERR;
                    end else begin
                        case (state_r)
                            RD0:     begin state_s = RD1;  lo_en_s = 1'b1; end
                            RD1:     begin state_s = DONE; hi_en_s = 1'b1; end
                            WR0:     state_s = WR1;
                            WR1:     state_s = DONE;
                            default: state_s = ERR;
                        endcase
                    end
                end
            end
            DONE, ERR: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Memory-bus address and write data for the upcoming state; the request is
    // taken straight from the inputs on the acceptance cycle.
    always_comb begin
        base_s      = lat_s ? {l2addr[31:3], 3'b000} : addr_r;
        store_s     = lat_s ? l2store : store_r;
        mem_addr_s  = 32'd0;
        mem_wdata_s = 32'd0;
        case (state_s)
            RD0:     mem_addr_s = base_s;
            RD1:     mem_addr_s = base_s + 32'd4;
            WR0:     begin mem_addr_s = base_s;         mem_wdata_s = store_s[31:0];  end
            WR1:     begin mem_addr_s = base_s + 32'd4; mem_wdata_s = store_s[63:32]; end
            default: begin mem_addr_s = 32'd0;          mem_wdata_s = 32'd0;          end
        endcase
    end

    // State, request latches, read data and registered bus outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            addr_r      <= 32'd0;
            store_r     <= 64'd0;
            l2load_r    <= 64'd0;
            l2state_r   <= L2_FREE;
            mem_ren_r   <= 1'b0;
            mem_wen_r   <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (lat_s) begin
                addr_r  <= {l2addr[31:3], 3'b000};
                store_r <= l2store;
            end
            if (lo_en_s) begin
                l2load_r[31:0] <= mem_rdata;
            end
            if (hi_en_s) begin
                l2load_r[63:32] <= mem_rdata;
            end
            l2state_r   <= l2state_of(state_s);
            mem_ren_r   <= (state_s == RD0) || (state_s == RD1);
            mem_wen_r   <= (state_s == WR0) || (state_s == WR1);
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign l2load    = l2load_r;
    assign l2state   = l2state_r;
    assign mem_ren   = mem_ren_r;
    assign mem_wen   = mem_wen_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed bench for l2_mem_bridge: reads, waited writes, timeout, error paths and
// mid-transaction reset, checked cycle by cycle against hand-computed values.
module tb_l2_mem_bridge;

    logic        CLK;
    logic        RST;
    logic        l2REN;
    logic        l2WEN;
    logic [31:0] l2addr;
    logic [63:0] l2store;
    logic [63:0] l2load;
    logic [1:0]  l2state;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        mem_error;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    l2_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .l2REN     (l2REN),
        .l2WEN     (l2WEN),
        .l2addr    (l2addr),
        .l2store   (l2store),
        .l2load    (l2load),
        .l2state   (l2state),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .mem_error (mem_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Move into the next cycle and settle past the active edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; l2REN = 1'b0; l2WEN = 1'b0; l2addr = 32'd0; l2store = 64'd0;
        mem_rdata = 32'd0; mem_busy = 1'b0; mem_error = 1'b0;
        cyc(); cyc();
        chk("rst_state", l2state, FREE);
        chk("rst_ren", mem_ren, 1'b0);
        chk("rst_wen", mem_wen, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_load", l2load, 64'd0);
        RST = 1'b0;
        cyc();

        // Zero-wait read at 0x100.
        l2REN = 1'b1; l2addr = 32'h100;
        chk("rd_c0_state", l2state, FREE);
        cyc();
        chk("rd_c1_state", l2state, BUSY);
        chk("rd_c1_ren", mem_ren, 1'b1);
        chk("rd_c1_addr", mem_addr, 32'h100);
        mem_rdata = 32'h1111_2222;
        cyc();
        chk("rd_c2_state", l2state, BUSY);
        chk("rd_c2_addr", mem_addr, 32'h104);
        mem_rdata = 32'h3333_4444;
        cyc();
        chk("rd_c3_state", l2state, ACCESS);
        chk("rd_c3_load", l2load, 64'h3333_4444_1111_2222);
        chk("rd_c3_ren", mem_ren, 1'b0);
        l2REN = 1'b0; mem_rdata = 32'd0;
        cyc();
        chk("rd_c4_state", l2state, FREE);

        // Write at 0x2008 with 3 busy cycles per beat; address change mid-request is ignored.
        l2WEN = 1'b1; l2addr = 32'h2008; l2store = 64'hDEAD_BEEF_CAFE_F00D; mem_busy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("wr_state", l2state, BUSY);
            chk("wr_wen", mem_wen, 1'b1);
            chk("wr_addr", mem_addr, (i <= 4) ? 32'h2008 : 32'h200C);
            chk("wr_data", mem_wdata, (i <= 4) ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
            if (i == 2) begin
                l2addr = 32'hFFF0; l2store = 64'd0;
            end
            mem_busy = !((i == 4) || (i == 8));
        end
        cyc();
        chk("wr_c9_state", l2state, ACCESS);
        chk("wr_c9_wen", mem_wen, 1'b0);
        chk("wr_c9_load", l2load, 64'h3333_4444_1111_2222);
        l2WEN = 1'b0; mem_busy = 1'b0;
        cyc();
        chk("wr_c10_state", l2state, FREE);

        // Read with memory stuck busy: timeout after 4 busy cycles in RD0.
        l2REN = 1'b1; l2addr = 32'h40; mem_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("to_state", l2state, BUSY);
            chk("to_ren", mem_ren, 1'b1);
            chk("to_addr", mem_addr, 32'h40);
        end
        cyc();
        chk("to_err_state", l2state, ERROR);
        chk("to_err_ren", mem_ren, 1'b0);
        l2REN = 1'b0;
        cyc();
        chk("to_free_state", l2state, FREE);
        chk("to_free_ren", mem_ren, 1'b0);
        chk("to_load", l2load, 64'h3333_4444_1111_2222);
        mem_busy = 1'b0;

        // Misaligned read.
        l2REN = 1'b1; l2addr = 32'h104;
        cyc();
        chk("mis_state", l2state, ERROR);
        chk("mis_ren", mem_ren, 1'b0);
        l2REN = 1'b0;
        cyc();
        chk("mis_free", l2state, FREE);
        chk("mis_ren2", mem_ren, 1'b0);

        // Read and write requested together.
        l2REN = 1'b1; l2WEN = 1'b1; l2addr = 32'h200;
        cyc();
        chk("both_state", l2state, ERROR);
        chk("both_ren", mem_ren, 1'b0);
        chk("both_wen", mem_wen, 1'b0);
        l2REN = 1'b0; l2WEN = 1'b0;
        cyc();
        chk("both_free", l2state, FREE);

        // Memory error on the first write beat: no second beat.
        l2WEN = 1'b1; l2addr = 32'h300; l2store = 64'h0123_4567_89AB_CDEF;
        cyc();
        chk("merr_wen", mem_wen, 1'b1);
        chk("merr_data", mem_wdata, 32'h89AB_CDEF);
        mem_error = 1'b1;
        cyc();
        chk("merr_state", l2state, ERROR);
        chk("merr_wen2", mem_wen, 1'b0);
        l2WEN = 1'b0; mem_error = 1'b0;
        cyc();
        chk("merr_free", l2state, FREE);
        chk("merr_wen3", mem_wen, 1'b0);

        // Reset during WR1 with memory busy.
        l2WEN = 1'b1; l2addr = 32'h400; l2store = 64'h5555_6666_7777_8888;
        cyc();
        chk("rst_wr0_addr", mem_addr, 32'h400);
        cyc();
        chk("rst_wr1_addr", mem_addr, 32'h404);
        chk("rst_wr1_data", mem_wdata, 32'h5555_6666);
        mem_busy = 1'b1; RST = 1'b1; l2WEN = 1'b0;
        cyc();
        chk("rst_mid_wen", mem_wen, 1'b0);
        chk("rst_mid_state", l2state, FREE);
        chk("rst_mid_load", l2load, 64'd0);
        RST = 1'b0; mem_busy = 1'b0;

        // Read after reset completes normally.
        l2REN = 1'b1; l2addr = 32'h500;
        cyc();
        chk("post_c1_addr", mem_addr, 32'h500);
        mem_rdata = 32'hAAAA_5555;
        cyc();
        chk("post_c2_addr", mem_addr, 32'h504);
        mem_rdata = 32'h0F0F_F0F0;
        cyc();
        chk("post_c3_state", l2state, ACCESS);
        chk("post_c3_load", l2load, 64'h0F0F_F0F0_AAAA_5555);
        l2REN = 1'b0;
        cyc();
        chk("post_c4_state", l2state, FREE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
